mem_port_arbiter: RTL and testbench

Shares the CPU's single byte-wide memory port between the instruction-fetch requester and the data load/store requester. Each granted request becomes one or two byte beats on the memory, little-endian, low byte first. The arbiter sits between the control sequencer and the memory inside the CPU system. It replaces direct Mem_CS/Mem_WR driving from the control unit.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/mem_arb_rr2.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types and encodings used by the memory port arbiter and its
// round-robin grant logic.
package cpu_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_LO   = 2'd1,
    ARB_HI   = 2'd2,
    ARB_ACK  = 2'd3
  } arb_state_e;

  localparam logic REQ_FETCH  = 1'b0;
  localparam logic REQ_DATA   = 1'b1;

  localparam logic MEM_CS_ON  = 1'b0;
  localparam logic MEM_CS_OFF = 1'b1;

  localparam logic MEM_READ   = 1'b0;
  localparam logic MEM_WRITE  = 1'b1;

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-input round-robin grant: a lone requester wins, a tie goes to the
// requester that was not granted last.
module mem_arb_rr2
  import cpu_pkg::*;
(
  input  logic Clock,
  input  logic Reset,
  input  logic req_fetch,
  input  logic req_data,
  input  logic take,
  output logic grant_id,
  output logic grant_any
);

  logic last_r;
  logic grant_id_s;

  // Pick the winner from the current requests and the last grant
  always_comb begin
    grant_id_s = REQ_FETCH;
    if (req_fetch && req_data) begin
      grant_id_s = (last_r == REQ_FETCH) ? REQ_DATA : REQ_FETCH;
    end else if (req_data) begin
      grant_id_s = REQ_DATA;
    end else begin
      grant_id_s = REQ_FETCH;
    end
  end

  // Remember who was granted whenever a grant is actually taken
  always_ff @(posedge Clock) begin
    if (Reset) begin
      last_r <= REQ_FETCH;
    end else if (take && grant_any) begin
      last_r <= grant_id_s;
    end else begin
      last_r <= last_r;
    end
  end

  assign grant_id  = grant_id_s;
  assign grant_any = req_fetch | req_data;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the byte-wide memory port between instruction fetch and data
// load/store; each grant becomes one or two little-endian byte beats.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              F_Req,
  input  logic [ADDR_W-1:0] F_Addr,
  output logic              F_Ack,
  output logic [15:0]       F_RData,
  input  logic              D_Req,
  input  logic              D_WE,
  input  logic              D_Wide,
  input  logic [ADDR_W-1:0] D_Addr,
  input  logic [15:0]       D_WData,
  output logic              D_Ack,
  output logic [15:0]       D_RData,
  output logic              Busy,
  output logic              Mem_CS,
  output logic              Mem_WR,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [7:0]        Mem_WData,
  input  logic [7:0]        Mem_RData
);

  arb_state_e        state_r, state_s;
  logic              gnt_r, gnt_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic              we_r, we_s;
  logic              wide_r, wide_s;
  logic [15:0]       wdata_r, wdata_s;
  logic [7:0]        lo_byte_r;
  logic              mem_cs_r, mem_cs_s;
  logic              mem_wr_r, mem_wr_s;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
  logic [7:0]        mem_wdata_r, mem_wdata_s;
  logic              f_ack_r, d_ack_r, busy_r;
  logic [15:0]       f_rdata_r, d_rdata_r;
  logic              ack_s;
  logic [15:0]       result_s;
  logic              take_s, arb_id_s, arb_any_s;

  assign take_s = (state_r == ARB_IDLE);

  mem_arb_rr2 u_rr (
    .Clock     (Clock),
    .Reset     (Reset),
    .req_fetch (F_Req),
    .req_data  (D_Req),
    .take      (take_s),
    .grant_id  (arb_id_s),
    .grant_any (arb_any_s)
  );

  // Next state, latched request and next memory-port drive values
  always_comb begin
    state_s     = state_r;
    gnt_s       = gnt_r;
    addr_s      = addr_r;
    we_s        = we_r;
    wide_s      = wide_r;
    wdata_s     = wdata_r;
    mem_cs_s    = MEM_CS_OFF;
    mem_wr_s    = MEM_READ;
    mem_addr_s  = mem_addr_r;
    mem_wdata_s = mem_wdata_r;
    ack_s       = 1'b0;
    result_s    = {Mem_RData, lo_byte_r};
    case (state_r)
      ARB_IDLE: begin
        if (arb_any_s) begin
          state_s = ARB_LO;
          gnt_s   = arb_id_s;
          if (arb_id_s == REQ_FETCH) begin
            addr_s  = F_Addr;
            we_s    = MEM_READ;
            wide_s  = 1'b1;
            wdata_s = 16'h0000;
          end else begin
            addr_s  = D_Addr;
            we_s    = D_WE;
            wide_s  = D_Wide;
            wdata_s = D_WData;
          end
          mem_cs_s    = MEM_CS_ON;
          mem_wr_s    = we_s;
          mem_addr_s  = addr_s;
          mem_wdata_s = wdata_s[7:0];
        end else begin
          state_s = ARB_IDLE;
        end
      end
      ARB_LO: begin
        if (wide_r) begin
          state_s     = ARB_HI;
          mem_cs_s    = MEM_CS_ON;
          mem_wr_s    = we_r;
          mem_addr_s  = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          mem_wdata_s = wdata_r[15:8];
        end else begin
          state_s  = ARB_ACK;
          ack_s    = 1'b1;
          result_s = {8'h00, Mem_RData};
        end
      end
      ARB_HI: begin
        state_s  = ARB_ACK;
        ack_s    = 1'b1;
        result_s = {Mem_RData, lo_byte_r};
      end
      ARB_ACK: begin
        state_s = ARB_IDLE;
      end
      default: begin
        state_s = ARB_IDLE;
      end
    endcase
  end

  // Control state, latched request and registered port outputs
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r     <= ARB_IDLE;
      gnt_r       <= REQ_FETCH;
      addr_r      <= '0;
      we_r        <= MEM_READ;
      wide_r      <= 1'b0;
      wdata_r     <= 16'h0000;
      lo_byte_r   <= 8'h00;
      mem_cs_r    <= MEM_CS_OFF;
      mem_wr_r    <= MEM_READ;
      mem_addr_r  <= '0;
      mem_wdata_r <= 8'h00;
      f_ack_r     <= 1'b0;
      d_ack_r     <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      gnt_r       <= gnt_s;
      addr_r      <= addr_s;
      we_r        <= we_s;
      wide_r      <= wide_s;
      wdata_r     <= wdata_s;
      lo_byte_r   <= (state_r == ARB_LO) ? Mem_RData : lo_byte_r;
      mem_cs_r    <= mem_cs_s;
      mem_wr_r    <= mem_wr_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      f_ack_r     <= ack_s && (gnt_r == REQ_FETCH);
      d_ack_r     <= ack_s && (gnt_r == REQ_DATA);
      busy_r      <= (state_s != ARB_IDLE);
    end
  end

  // Read results; a reset that lands mid-transfer must not disturb them
  always_ff @(posedge Clock) begin
    if (Reset) begin
      if (state_r == ARB_IDLE) begin
        f_rdata_r <= 16'h0000;
        d_rdata_r <= 16'h0000;
      end else begin
        f_rdata_r <= f_rdata_r;
        d_rdata_r <= d_rdata_r;
      end
    end else if (ack_s && (we_r == MEM_READ)) begin
      f_rdata_r <= (gnt_r == REQ_FETCH) ? result_s : f_rdata_r;
      d_rdata_r <= (gnt_r == REQ_DATA)  ? result_s : d_rdata_r;
    end else begin
      f_rdata_r <= f_rdata_r;
      d_rdata_r <= d_rdata_r;
    end
  end

  assign F_Ack     = f_ack_r;
  assign D_Ack     = d_ack_r;
  assign F_RData   = f_rdata_r;
  assign D_RData   = d_rdata_r;
  assign Busy      = busy_r;
  assign Mem_CS    = mem_cs_r;
  assign Mem_WR    = mem_wr_r;
  assign Mem_Addr  = mem_addr_r;
  assign Mem_WData = mem_wdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requesters push expected results,
// a negedge monitor compares them against what the arbiter presents.
module tb_mem_port_arbiter;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        F_Req = 1'b0;
  logic [15:0] F_Addr = 16'h0000;
  logic        F_Ack;
  logic [15:0] F_RData;
  logic        D_Req = 1'b0;
  logic        D_WE = 1'b0;
  logic        D_Wide = 1'b0;
  logic [15:0] D_Addr = 16'h0000;
  logic [15:0] D_WData = 16'h0000;
  logic        D_Ack;
  logic [15:0] D_RData;
  logic        Busy;
  logic        Mem_CS;
  logic        Mem_WR;
  logic [15:0] Mem_Addr;
  logic [7:0]  Mem_WData;
  logic [7:0]  Mem_RData;

  always #5 Clock = ~Clock;

  mem_port_arbiter #(.ADDR_W(16)) dut (
    .Clock(Clock), .Reset(Reset),
    .F_Req(F_Req), .F_Addr(F_Addr), .F_Ack(F_Ack), .F_RData(F_RData),
    .D_Req(D_Req), .D_WE(D_WE), .D_Wide(D_Wide), .D_Addr(D_Addr),
    .D_WData(D_WData), .D_Ack(D_Ack), .D_RData(D_RData),
    .Busy(Busy), .Mem_CS(Mem_CS), .Mem_WR(Mem_WR), .Mem_Addr(Mem_Addr),
    .Mem_WData(Mem_WData), .Mem_RData(Mem_RData)
  );

  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];
  bit         mem_loaded = 1'b0;

  assign Mem_RData = mem[Mem_Addr];

  // Memory: loaded from the reference image at the first edge, then commits writes
  always @(posedge Clock) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 65536; i++) mem[i] <= ref_mem[i];
      mem_loaded <= 1'b1;
    end else if (!Mem_CS && Mem_WR) begin
      mem[Mem_Addr] <= Mem_WData;
    end
  end

  typedef struct {
    logic        we;
    logic        wide;
    logic [15:0] addr;
    logic [15:0] rdata;
  } exp_t;

  exp_t        fq[$];
  exp_t        dq[$];
  logic [15:0] beats[$];
  int          errors = 0;
  int          checks = 0;
  int          f_ack_cnt = 0;
  int          d_ack_cnt = 0;
  logic [15:0] f_last = 16'h0000;
  logic [15:0] d_last = 16'h0000;

  function automatic void check16(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  function automatic void check1(string name, logic act, logic exp);
    check16(name, {15'd0, act}, {15'd0, exp});
  endfunction

  function automatic void on_ack(bit is_data);
    exp_t e;
    if (is_data ? (dq.size() == 0) : (fq.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_ack: got ack on %s, expected none", is_data ? "data" : "fetch");
      return;
    end
    if (is_data) begin
      e = dq.pop_front();
      d_ack_cnt++;
    end else begin
      e = fq.pop_front();
      f_ack_cnt++;
    end
    check16("beat_count", 16'(beats.size()), e.wide ? 16'd2 : 16'd1);
    if (beats.size() >= 1) check16("beat0_addr", beats[0], e.addr);
    if (e.wide && beats.size() >= 2) check16("beat1_addr", beats[1], e.addr + 16'd1);
    check16(is_data ? "D_RData" : "F_RData", is_data ? D_RData : F_RData, e.rdata);
    check1("cs_high_in_ack", Mem_CS, 1'b1);
    beats.delete();
  endfunction

  // Monitor: gathers memory beats and settles expectations on each Ack
  always @(negedge Clock) begin
    if (!Reset) begin
      if (!Mem_CS) begin
        check1("busy_during_beat", Busy, 1'b1);
        beats.push_back(Mem_Addr);
      end
      if (F_Ack) on_ack(1'b0);
      if (D_Ack) on_ack(1'b1);
      if (!Busy) beats.delete();
    end
  end

  task automatic wait_ack(input bit is_data, input int lat);
    int k = 0;
    bit got = 1'b0;
    while (!got && k < 40) begin
      @(negedge Clock);
      if (is_data ? D_Ack : F_Ack) got = 1'b1;
      else k++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got no %s ack after %0d cycles, expected one", is_data ? "data" : "fetch", k);
    end else if (lat >= 0) begin
      check16("ack_latency", 16'(k), 16'(lat));
    end
  endtask

  task automatic issue_fetch(input logic [15:0] a, input int lat);
    exp_t e;
    logic [15:0] a1;
    a1 = a + 16'd1;
    e.we = 1'b0;
    e.wide = 1'b1;
    e.addr = a;
    e.rdata = {ref_mem[a1], ref_mem[a]};
    f_last = e.rdata;
    fq.push_back(e);
    @(posedge Clock); #1;
    F_Addr = a;
    F_Req = 1'b1;
    wait_ack(1'b0, lat);
    @(posedge Clock); #1;
    F_Req = 1'b0;
    F_Addr = 16'($urandom);
  endtask

  task automatic issue_data(input logic we, input logic wide, input logic [15:0] a,
                            input logic [15:0] wd, input int lat);
    exp_t e;
    logic [15:0] a1;
    a1 = a + 16'd1;
    e.we = we;
    e.wide = wide;
    e.addr = a;
    if (we) begin
      ref_mem[a] = wd[7:0];
      if (wide) ref_mem[a1] = wd[15:8];
      e.rdata = d_last;
    end else begin
      e.rdata = wide ? {ref_mem[a1], ref_mem[a]} : {8'h00, ref_mem[a]};
      d_last = e.rdata;
    end
    dq.push_back(e);
    @(posedge Clock); #1;
    D_WE = we;
    D_Wide = wide;
    D_Addr = a;
    D_WData = wd;
    D_Req = 1'b1;
    wait_ack(1'b1, lat);
    @(posedge Clock); #1;
    D_Req = 1'b0;
    D_WE = 1'($urandom);
    D_Wide = 1'($urandom);
    D_Addr = 16'($urandom);
    D_WData = 16'($urandom);
  endtask

  initial begin
    int acks_before;
    int bad;
    exp_t e;
    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'($urandom);
    ref_mem[16'h0010] = 8'h34;
    ref_mem[16'h0011] = 8'h12;
    ref_mem[16'h0020] = 8'hA5;

    repeat (3) @(posedge Clock);
    #1 Reset = 1'b0;

    // Reset state and quiet idle
    repeat (5) begin
      @(negedge Clock);
      check1("idle_cs", Mem_CS, 1'b1);
      check1("idle_busy", Busy, 1'b0);
      check1("idle_f_ack", F_Ack, 1'b0);
      check1("idle_d_ack", D_Ack, 1'b0);
    end
    check1("rst_mem_wr", Mem_WR, 1'b0);
    check16("rst_mem_addr", Mem_Addr, 16'h0000);
    check16("rst_mem_wdata", {8'h00, Mem_WData}, 16'h0000);
    check16("rst_f_rdata", F_RData, 16'h0000);
    check16("rst_d_rdata", D_RData, 16'h0000);

    // Directed transfers with exact latency
    issue_fetch(16'h0010, 3);
    check16("fetch_0010", F_RData, 16'h1234);
    issue_data(1'b1, 1'b1, 16'hFFFF, 16'hBEEF, 3);
    check16("wrap_lo_byte", {8'h00, mem[16'hFFFF]}, 16'h00EF);
    check16("wrap_hi_byte", {8'h00, mem[16'h0000]}, 16'h00BE);
    issue_data(1'b0, 1'b0, 16'h0020, 16'h5A5A, 2);
    check16("byte_read_0020", D_RData, 16'h00A5);

    // Reset during the HI beat of a word read
    acks_before = d_ack_cnt;
    @(posedge Clock); #1;
    D_WE = 1'b0; D_Wide = 1'b1; D_Addr = 16'h0050; D_Req = 1'b1;
    repeat (3) @(negedge Clock);
    check1("hi_beat_cs", Mem_CS, 1'b0);
    #1 Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    D_Req = 1'b0;
    @(negedge Clock);
    check1("abort_cs", Mem_CS, 1'b1);
    check1("abort_busy", Busy, 1'b0);
    check1("abort_ack", D_Ack, 1'b0);
    check16("abort_d_rdata", D_RData, 16'h00A5);
    repeat (4) @(negedge Clock);
    check16("abort_no_ack", 16'(d_ack_cnt - acks_before), 16'd0);

    // Both requesters held high from reset: D, F, D, F
    Reset = 1'b1;
    F_Req = 1'b1; F_Addr = 16'h0030;
    D_Req = 1'b1; D_WE = 1'b0; D_Wide = 1'b1; D_Addr = 16'h0040;
    for (int i = 0; i < 2; i++) begin
      e.we = 1'b0; e.wide = 1'b1;
      e.addr = 16'h0040; e.rdata = {ref_mem[16'h0041], ref_mem[16'h0040]};
      dq.push_back(e);
      d_last = e.rdata;
      e.addr = 16'h0030; e.rdata = {ref_mem[16'h0031], ref_mem[16'h0030]};
      fq.push_back(e);
      f_last = e.rdata;
    end
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
    begin
      int k = 0;
      int n = 0;
      while (n < 4 && k < 40) begin
        @(negedge Clock);
        if (F_Ack || D_Ack) begin
          check1("tie_winner_is_data", D_Ack, (n % 2) == 0);
          check16("tie_ack_cycle", 16'(k), 16'(3 + 4 * n));
          n++;
        end
        k++;
      end
      if (n < 4) begin
        checks++;
        errors++;
        $display("FAIL tie_timeout: got %0d acks, expected 4", n);
      end
    end
    @(posedge Clock); #1;
    F_Req = 1'b0;
    D_Req = 1'b0;

    // Random contention: fetch in the low half, data in the high half
    fork
      begin
        repeat (25) begin
          issue_fetch(16'($urandom_range(0, 32766)), -1);
          repeat ($urandom_range(0, 3)) @(posedge Clock);
        end
      end
      begin
        repeat (35) begin
          issue_data(1'($urandom), 1'($urandom), 16'($urandom_range(32768, 65534)),
                     16'($urandom), -1);
          repeat ($urandom_range(0, 3)) @(posedge Clock);
        end
      end
    join

    repeat (5) @(posedge Clock);
    check16("fetch_queue_drained", 16'(fq.size()), 16'd0);
    check16("data_queue_drained", 16'(dq.size()), 16'd0);
    bad = 0;
    for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) bad++;
    check16("mem_image_mismatches", 16'(bad), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
